// File: rtl/rs232tx.sv
// rs232tx: 8-bit asynchronous serial transmitter, LSB first, no parity,
// 1 or 2 stop bits. Accepts a byte on valid && ready and frames it on TX.
module rs232tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       TX
);

  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Reject parameter values the frame logic cannot represent
  generate
    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
      $error("rs232tx: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic [1:0]    state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, ready_n;
  logic          bit_end_c;

  // Last clk cycle of the current serial bit
  assign bit_end_c = (baud == BAUD_LAST);

  // State and registered outputs; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      baud   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      TX     <= 1'b1;
      ready  <= 1'b1;
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      TX     <= tx_n;
      ready  <= ready_n;
    end
  end

  // Next-state, bit sequencing and next output levels
  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    tx_n     = TX;
    ready_n  = ready;

    if (state != IDLE) begin
      baud_n = bit_end_c ? '0 : baud + BW'(1);
    end

    case (state)
      IDLE: begin
        tx_n    = 1'b1;
        ready_n = 1'b1;
        if (valid) begin
          shreg_n  = data;
          baud_n   = '0;
          bitcnt_n = '0;
          tx_n     = 1'b0;
          ready_n  = 1'b0;
          state_n  = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          tx_n     = shreg[0];
          shreg_n  = {1'b0, shreg[7:1]};
          bitcnt_n = '0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bitcnt == 3'd7) begin
            tx_n     = 1'b1;
            bitcnt_n = '0;
            state_n  = STOP;
          end else begin
            tx_n     = shreg[0];
            shreg_n  = {1'b0, shreg[7:1]};
            bitcnt_n = bitcnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (bitcnt == STOP_LAST) begin
            tx_n    = 1'b1;
            ready_n = 1'b1;
            state_n = IDLE;
          end else begin
            bitcnt_n = bitcnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rs232tx.sv
// Bench for rs232tx: a frame-level reference model checks both instances every
// cycle; directed frames are pinned with hand-computed literals, and a second
// instance (104 clk/bit, 2 stop bits) is looped into a bench-side receiver.
module tb_rs232tx;

  logic       clk = 1'b0;
  logic [1:0] rst_v;
  logic [1:0] valid_v;
  logic [7:0] data_v [2];
  logic       tx0, tx1, rdy0, rdy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs232tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .data(data_v[0]), .valid(valid_v[0]),
    .ready(rdy0), .TX(tx0)
  );

  rs232tx #(.CLKS_PER_BIT(104), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst_v[1]), .data(data_v[1]), .valid(valid_v[1]),
    .ready(rdy1), .TX(tx1)
  );

  // Reference model: a frame is a byte plus the cycle offset k since acceptance
  int         cpb [2] = '{4, 104};
  int         sb  [2] = '{1, 2};
  bit         busy [2];
  int         k    [2];
  logic [7:0] mb   [2];
  int         acc_cnt [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        busy[i] = 1'b0;
      end else if (!busy[i]) begin
        if (valid_v[i]) begin
          busy[i]    = 1'b1;
          k[i]       = 1;
          mb[i]      = data_v[i];
          acc_cnt[i] = acc_cnt[i] + 1;
        end
      end else begin
        k[i] = k[i] + 1;
        if (k[i] > (9 + sb[i]) * cpb[i]) busy[i] = 1'b0;
      end
    end
  end

  function automatic logic exp_tx(input int i);
    int slot;
    if (!busy[i]) return 1'b1;
    slot = (k[i] - 1) / cpb[i];
    if (slot == 0) return 1'b0;
    if (slot <= 8) return mb[i][slot-1];
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    check_b("tx0",    tx0,  exp_tx(0));
    check_b("ready0", rdy0, !busy[0]);
    check_b("tx1",    tx1,  exp_tx(1));
    check_b("ready1", rdy1, !busy[1]);
  end

  // Bench-side receiver for instance 1: mid-bit sampling, plus idle-high run length
  logic [7:0] rxq [$];
  logic [7:0] rx_sh;
  bit         rx_act = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_cnt, rx_j, hi_run = 0, last_run = 0;
  int         rx_start_bad = 0, rx_stop_bad = 0;

  always @(negedge clk) begin
    if (rx_act) begin
      rx_cnt = rx_cnt + 1;
      if (rx_cnt >= 52 && (rx_cnt - 52) % 104 == 0) begin
        rx_j = (rx_cnt - 52) / 104;
        if (rx_j == 0) begin
          if (tx1 !== 1'b0) rx_start_bad++;
        end else if (rx_j <= 8) begin
          rx_sh[rx_j-1] = tx1;
        end else begin
          if (tx1 !== 1'b1) rx_stop_bad++;
          rxq.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end else if (rx_prev === 1'b1 && tx1 === 1'b0 && !rst_v[1]) begin
      rx_act = 1'b1;
      rx_cnt = 1;
      if (rxq.size() > 0) last_run = hi_run;
    end
    hi_run  = (tx1 === 1'b1) ? hi_run + 1 : 0;
    rx_prev = tx1;
  end

  // Present a byte on instance 0 and wait (bounded) for the model to accept it
  task automatic send0(input logic [7:0] b, input bit hold);
    int  a;
    bit  got;
    a   = acc_cnt[0];
    got = 1'b0;
    valid_v[0] = 1'b1;
    data_v[0]  = b;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (acc_cnt[0] != a) got = 1'b1;
    end
    check("accept0_timeout", int'(got), 1);
    if (!hold) valid_v[0] = 1'b0;
  endtask

  // Walk one 4-clk/bit frame from its first cycle against a hand-written slot pattern
  task automatic frame_stats(input logic [9:0] pat, input int lows_exp, input string nm);
    int lows, rlow, slot_bad;
    lows = 0; rlow = 0; slot_bad = 0;
    for (int kk = 1; kk <= 44; kk++) begin
      if (kk > 1) @(negedge clk);
      if (tx0 === 1'b0) lows++;
      if (rdy0 === 1'b0) rlow++;
      if (kk <= 40 && tx0 !== pat[(kk-1)/4]) slot_bad++;
    end
    check({nm, "_lows"}, lows, lows_exp);
    check({nm, "_busy_cycles"}, rlow, 40);
    check({nm, "_pattern"}, slot_bad, 0);
  endtask

  task automatic inst0_tests();
    int  a, fall;
    logic prev;
    logic [7:0] rb;

    // Single byte and extremes
    @(negedge clk);
    send0(8'h55, 1'b0); frame_stats(10'b1010101010, 20, "b55");
    send0(8'h00, 1'b0); frame_stats(10'b1000000000, 36, "b00");
    send0(8'hFF, 1'b0); frame_stats(10'b1111111110, 4,  "bFF");

    // Back-to-back with valid held; data changes right after acceptance
    send0(8'hA5, 1'b1);
    data_v[0] = 8'h3C;
    a = acc_cnt[0];
    fall = 0;
    prev = tx0;
    for (int kk = 1; kk <= 100; kk++) begin
      if (kk > 1) @(negedge clk);
      if (kk == 41) begin
        check_b("b2b_idle_tx", tx0, 1'b1);
        check_b("b2b_idle_ready", rdy0, 1'b1);
      end
      if (kk > 40 && fall == 0 && prev === 1'b1 && tx0 === 1'b0) fall = kk;
      if (acc_cnt[0] != a) valid_v[0] = 1'b0;
      prev = tx0;
    end
    check("b2b_second_start", fall, 42);
    check("b2b_accepts", acc_cnt[0] - a, 1);

    // Busy ignore: a mid-frame valid pulse is never accepted
    a = acc_cnt[0];
    send0(8'h81, 1'b0);
    for (int kk = 1; kk <= 50; kk++) begin
      if (kk > 1) @(negedge clk);
      if (kk == 10) begin valid_v[0] = 1'b1; data_v[0] = 8'h7E; end
      if (kk == 11) valid_v[0] = 1'b0;
    end
    check("busy_ignore_accepts", acc_cnt[0] - a, 1);

    // Reset during data bit 3 of 0xC3
    send0(8'hC3, 1'b0);
    repeat (17) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check_b("rst_mid_tx", tx0, 1'b1);
    check_b("rst_mid_ready", rdy0, 1'b1);
    send0(8'h12, 1'b0); frame_stats(10'b1000100100, 28, "b12");

    // Reset and valid on the same edge: nothing accepted
    a = acc_cnt[0];
    rst_v[0] = 1'b1; valid_v[0] = 1'b1; data_v[0] = 8'h99;
    @(negedge clk);
    rst_v[0] = 1'b0; valid_v[0] = 1'b0;
    check_b("rst_valid_ready", rdy0, 1'b1);
    check_b("rst_valid_tx", tx0, 1'b1);
    repeat (5) @(negedge clk);
    check("rst_valid_accepts", acc_cnt[0] - a, 0);

    // Random traffic with stray valid pulses and occasional resets
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      rb = 8'($urandom);
      send0(rb, 1'b0);
      for (int w = 0; w < 50; w++) begin
        @(negedge clk);
        valid_v[0] = 1'b0;
        rst_v[0]   = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          valid_v[0] = 1'b1;
          data_v[0]  = 8'($urandom);
        end else if ($urandom_range(0, 60) == 0) begin
          rst_v[0] = 1'b1;
        end
      end
      valid_v[0] = 1'b0;
      rst_v[0]   = 1'b0;
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic inst1_stream();
    int a, sent;
    sent = 0;
    data_v[1]  = 8'h00;
    valid_v[1] = 1'b1;
    a = acc_cnt[1];
    for (int n = 0; n < 60000 && sent < 32; n++) begin
      @(negedge clk);
      if (acc_cnt[1] != a) begin
        a = acc_cnt[1];
        sent++;
        data_v[1] = 8'(sent);
      end
    end
    valid_v[1] = 1'b0;
    check("stream_sent", sent, 32);
    for (int n = 0; n < 3000 && busy[1]; n++) @(negedge clk);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_v      = 2'b11;
    valid_v    = 2'b00;
    data_v[0]  = 8'h00;
    data_v[1]  = 8'h00;
    repeat (3) @(negedge clk);
    check_b("reset_tx0", tx0, 1'b1);
    check_b("reset_ready0", rdy0, 1'b1);
    check_b("reset_tx1", tx1, 1'b1);
    check_b("reset_ready1", rdy1, 1'b1);
    rst_v = 2'b00;

    fork
      inst0_tests();
      inst1_stream();
    join

    check("rx_count", rxq.size(), 32);
    for (int i = 0; i < rxq.size() && i < 32; i++)
      check($sformatf("rx_byte%0d", i), int'(rxq[i]), i);
    check("rx_start_bits", rx_start_bad, 0);
    check("rx_stop_bits", rx_stop_bad, 0);
    check("stop_plus_idle_high", last_run, 209);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
